// File: rtl/keypad_entry.sv
// Keypad digit entry: collects up to four BCD digits from PS2 set-2 keypad
// scancodes. Backspace removes the newest digit, Esc clears the entry and
// Enter commits it to value_out.
module keypad_entry (
    input  logic        ck,
    input  logic        reset_n,
    input  logic [7:0]  key_code,
    output logic [15:0] digits_out,
    output logic [2:0]  digit_count,
    output logic [15:0] value_out,
    output logic        value_valid,
    output logic        key_event,
    output logic        error
);

    localparam int unsigned CODE_W  = 8;
    localparam int unsigned DIGIT_W = 4;

    localparam logic [CODE_W-1:0] CODE_BKSP  = 8'h66;
    localparam logic [CODE_W-1:0] CODE_ESC   = 8'h76;
    localparam logic [CODE_W-1:0] CODE_ENTER = 8'h5A;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state;
    logic [CODE_W-1:0]   last_code;
    logic                event_c;
    logic                is_digit_c;
    logic [DIGIT_W-1:0]  digit_c;

    // A new event is a nonzero code that differs from the one seen on the previous edge.
    assign event_c = (key_code != '0) && (key_code != last_code);

    // Map keypad scancodes to their BCD digit.
    always_comb begin
        is_digit_c = 1'b1;
        digit_c    = '0;
        case (key_code)
            8'h70:   digit_c = 4'd0;
            8'h69:   digit_c = 4'd1;
            8'h72:   digit_c = 4'd2;
            8'h7A:   digit_c = 4'd3;
            8'h6B:   digit_c = 4'd4;
            8'h73:   digit_c = 4'd5;
            8'h74:   digit_c = 4'd6;
            8'h6C:   digit_c = 4'd7;
            8'h75:   digit_c = 4'd8;
            8'h7D:   digit_c = 4'd9;
            default: is_digit_c = 1'b0;
        endcase
    end

    // Entry FSM with registered data outputs and single-cycle pulses.
    always_ff @(posedge ck or negedge reset_n) begin
        if (!reset_n) begin
            state       <= EMPTY;
            last_code   <= '0;
            digits_out  <= '0;
            digit_count <= '0;
            value_out   <= '0;
            value_valid <= 1'b0;
            key_event   <= 1'b0;
            error       <= 1'b0;
        end else begin
            last_code   <= key_code;
            key_event   <= event_c;
            error       <= 1'b0;
            value_valid <= 1'b0;
            if (event_c) begin
                if (is_digit_c) begin
                    if (state == FULL) begin
                        error <= 1'b1;
                    end else begin
                        digits_out  <= {digits_out[11:0], digit_c};
                        digit_count <= digit_count + 3'd1;
                        state       <= (digit_count == 3'd3) ? FULL : ENTRY;
                    end
                end else if (key_code == CODE_BKSP) begin
                    // Backspace on an empty entry is silently ignored.
                    if (state != EMPTY) begin
                        digits_out  <= {4'h0, digits_out[15:4]};
                        digit_count <= digit_count - 3'd1;
                        state       <= (digit_count == 3'd1) ? EMPTY : ENTRY;
                    end
                end else if (key_code == CODE_ESC) begin
                    digits_out  <= '0;
                    digit_count <= '0;
                    state       <= EMPTY;
                end else if (key_code == CODE_ENTER) begin
                    if (state == EMPTY) begin
                        error <= 1'b1;
                    end else begin
                        value_out   <= digits_out;
                        value_valid <= 1'b1;
                        digits_out  <= '0;
                        digit_count <= '0;
                        state       <= EMPTY;
                    end
                end else begin
                    error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a queue-based model of the digit entry is compared
// against the DUT after every clock edge, with directed scenarios pinned by
// literal expectations followed by randomized key traffic.
module tb_keypad_entry;

    logic        ck;
    logic        reset_n;
    logic [7:0]  key_code;
    logic [15:0] digits_out;
    logic [2:0]  digit_count;
    logic [15:0] value_out;
    logic        value_valid;
    logic        key_event;
    logic        error;

    keypad_entry dut (
        .ck          (ck),
        .reset_n     (reset_n),
        .key_code    (key_code),
        .digits_out  (digits_out),
        .digit_count (digit_count),
        .value_out   (value_out),
        .value_valid (value_valid),
        .key_event   (key_event),
        .error       (error)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int checks = 0;
    int errors = 0;

    // Model state: entered digits oldest first, last sampled code, committed value.
    logic [3:0]  m_q[$];
    logic [7:0]  m_last;
    logic [15:0] m_value;
    logic        m_vv, m_ke, m_err;

    // Pulse counters observed on the DUT, reset per scenario.
    int n_ke, n_err, n_vv;

    logic [7:0] kp [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                            8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pack_digits();
        logic [15:0] v = '0;
        foreach (m_q[i]) v = (v << 4) | 16'(m_q[i]);
        return v;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_last  = '0;
        m_value = '0;
        m_vv = 0; m_ke = 0; m_err = 0;
    endfunction

    function automatic void model_step(input logic [7:0] code);
        int d = -1;
        logic ev;
        ev = (code != 8'h00) && (code != m_last);
        m_last = code;
        m_ke = ev; m_err = 0; m_vv = 0;
        if (!ev) return;
        for (int i = 0; i < 10; i++) if (kp[i] == code) d = i;
        if (d >= 0) begin
            if (m_q.size() == 4) m_err = 1;
            else m_q.push_back(4'(d));
        end else if (code == 8'h66) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
        end else if (code == 8'h76) begin
            m_q.delete();
        end else if (code == 8'h5A) begin
            if (m_q.size() == 0) m_err = 1;
            else begin
                m_value = pack_digits();
                m_vv = 1;
                m_q.delete();
            end
        end else begin
            m_err = 1;
        end
    endfunction

    task automatic compare_all();
        chk("digits_out",  32'(digits_out),  32'(pack_digits()));
        chk("digit_count", 32'(digit_count), 32'(m_q.size()));
        chk("value_out",   32'(value_out),   32'(m_value));
        chk("value_valid", 32'(value_valid), 32'(m_vv));
        chk("key_event",   32'(key_event),   32'(m_ke));
        chk("error",       32'(error),       32'(m_err));
        n_ke  += int'(key_event);
        n_err += int'(error);
        n_vv  += int'(value_valid);
    endtask

    task automatic clear_counts();
        n_ke = 0; n_err = 0; n_vv = 0;
    endtask

    // Called at a falling edge; presents a code, checks after the next rising edge, returns at the next falling edge.
    task automatic step(input logic [7:0] code);
        key_code = code;
        model_step(code);
        @(posedge ck);
        #1;
        compare_all();
        @(negedge ck);
    endtask

    // Asynchronous reset pulse between edges; releases at a falling edge with hold_code applied.
    task automatic async_reset(input logic [7:0] hold_code);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (3) begin
            @(posedge ck);
            #1;
            compare_all();
        end
        @(negedge ck);
        key_code = hold_code;
        reset_n  = 1'b1;
    endtask

    initial begin
        reset_n  = 1'b0;
        key_code = 8'h00;
        model_reset();
        clear_counts();
        repeat (2) @(posedge ck);
        #1;
        chk("reset_digits", 32'(digits_out), 32'h0);
        chk("reset_count",  32'(digit_count), 32'h0);
        chk("reset_value",  32'(value_out), 32'h0);
        @(negedge ck);
        reset_n = 1'b1;

        // Digit entry 1,2,3,4 with gaps.
        clear_counts();
        foreach (kp[i]) ;
        begin
            logic [7:0] seq [4] = '{8'h69, 8'h72, 8'h7A, 8'h6B};
            foreach (seq[i]) begin
                step(seq[i]); step(seq[i]);
                step(8'h00);  step(8'h00);
            end
        end
        chk("entry_digits", 32'(digits_out), 32'h1234);
        chk("entry_count",  32'(digit_count), 32'd4);
        chk("entry_events", 32'(n_ke), 32'd4);
        chk("entry_errors", 32'(n_err), 32'd0);

        // Overflow while full.
        clear_counts();
        step(8'h73);
        step(8'h00);
        chk("ovf_errors", 32'(n_err), 32'd1);
        chk("ovf_events", 32'(n_ke), 32'd1);
        chk("ovf_digits", 32'(digits_out), 32'h1234);

        // Backspace then commit.
        clear_counts();
        step(8'h66);
        chk("bksp_digits", 32'(digits_out), 32'h0123);
        step(8'h5A);
        chk("commit_value", 32'(value_out), 32'h0123);
        chk("commit_vv",    32'(value_valid), 32'd1);
        step(8'h00);
        chk("commit_vv_low", 32'(value_valid), 32'd0);
        chk("commit_digits", 32'(digits_out), 32'h0);
        chk("commit_count",  32'(digit_count), 32'd0);

        // Empty enter and unknown code.
        async_reset(8'h00);
        clear_counts();
        step(8'h5A);
        step(8'h1C);
        step(8'h00);
        chk("empty_errors", 32'(n_err), 32'd2);
        chk("empty_vv",     32'(n_vv), 32'd0);
        chk("empty_value",  32'(value_out), 32'h0);
        chk("empty_digits", 32'(digits_out), 32'h0);

        // Held codes and direct code change.
        async_reset(8'h00);
        clear_counts();
        repeat (10) step(8'h69);
        repeat (10) step(8'h72);
        chk("hold_events", 32'(n_ke), 32'd2);
        chk("hold_digits", 32'(digits_out), 32'h0012);
        step(8'h00);

        // Reset mid-entry with a code held across release.
        step(8'h7D);
        step(8'h75);
        clear_counts();
        async_reset(8'h70);
        chk("rst_vv_none", 32'(n_vv), 32'd0);
        clear_counts();
        repeat (3) step(8'h70);
        chk("rst_hold_events", 32'(n_ke), 32'd1);
        chk("rst_hold_digits", 32'(digits_out), 32'h0000);
        chk("rst_hold_count",  32'(digit_count), 32'd1);
        step(8'h00);

        // Randomized key traffic, including held codes and occasional resets.
        begin
            logic [7:0] code = 8'h00;
            for (int n = 0; n < 3000; n++) begin
                int r = int'($urandom_range(0, 99));
                if (r < 30)      code = code;
                else if (r < 50) code = 8'h00;
                else if (r < 75) code = kp[$urandom_range(0, 9)];
                else if (r < 83) code = 8'h66;
                else if (r < 87) code = 8'h76;
                else if (r < 95) code = 8'h5A;
                else if (r < 99) code = 8'($urandom_range(1, 255));
                else begin
                    async_reset(code);
                end
                step(code);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Port: ck  input  1  system clock; all state updates on rising edge.
REQ-002 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-003 Port: key_code  input  8  PS2 set-2 scancode from the keyboard stage; 8'h00 means no key.
REQ-004 Port: digits_out  output  16  four BCD digits being entered; [3:0] is the newest digit.
REQ-005 Port: digit_count  output  3  number of digits entered, 0..4.
REQ-006 Port: value_out  output  16  last committed 4-digit BCD value.
REQ-007 Port: value_valid  output  1  one-cycle pulse when value_out is updated.
REQ-008 Port: key_event  output  1  one-cycle pulse for every accepted key event.
REQ-009 Port: error  output  1  one-cycle pulse for an unknown code, a digit when full, or Enter when empty.

Function
REQ-010 Recognised codes (keycodes.vh values):
- KP_0..KP_9 = 70,69,72,7A,6B,73,74,6C,75,7D (hex), mapping to digits 0..9.
- BKSP = 66, ESC = 76, ENTER = 5A.
REQ-011 Register last_code holds key_code from the previous edge; reset value 8'h00.
REQ-012 Key event when key_code != 0 and key_code != last_code; a code held for N cycles yields exactly one event.
REQ-013 Nonzero-to-different-nonzero code change is a new event; a return to 0 is never an event.
REQ-014 The block reacts on the same edge that samples key_code. Latency is 1 cycle: key_code presented before edge N gives updated outputs and pulses after edge N.
REQ-015 FSM states: EMPTY (count 0), ENTRY (count 1..3), FULL (count 4). digit_count is always consistent with the state.
REQ-016 Digit in EMPTY/ENTRY:
- digits_out <= {digits_out[11:0], d}; count+1.
- Moves to FULL when count reaches 4.
REQ-017 Digit in FULL: digits_out unchanged; error pulse.
REQ-018 BKSP in ENTRY/FULL:
- digits_out <= {4'h0, digits_out[15:4]}; count-1.
- Next state is EMPTY at 0, else ENTRY.
REQ-019 BKSP in EMPTY: no change, no error.
REQ-020 ESC in any state: digits_out <= 0, count <= 0, state EMPTY, no error.
REQ-021 ENTER with count >= 1:
- value_out <= digits_out; value_valid pulse.
- digits_out <= 0, count <= 0, state EMPTY.
REQ-022 ENTER in EMPTY: value_out unchanged, no value_valid, error pulse.
REQ-023 Unrecognised nonzero code: no state or data change; error pulse.
REQ-024 key_event pulses for every event in REQ-012, including events that also pulse error. key_event, error and value_valid are each 0 in every cycle without an event.
REQ-025 All outputs are registered.
REQ-026 No arithmetic beyond the 3-bit count. Count never wraps: it saturates per REQ-017 and REQ-019.

Reset
REQ-027 While reset_n=0, all outputs and registers are 0 and the state is EMPTY, regardless of ck.
REQ-028 Reset asserted mid-entry discards partial digits and a pending commit. No value_valid is generated for the discarded entry.
REQ-029 last_code clears on reset. A nonzero key_code held across reset release is an event on the first rising edge after release.

Verification
REQ-030 Digit entry: after reset, apply 69,00,72,00,7A,00,6B,00, each for 2 cycles.
- Required: digits_out=16'h1234, digit_count=4.
- Exactly 4 key_event pulses, 0 error pulses.
REQ-031 Overflow: with state FULL at 16'h1234, apply 73.
- Required: one error pulse, one key_event pulse, digits_out stays 16'h1234.
REQ-032 Backspace and commit: from 16'h1234, apply 66 then 5A.
- Required: digits_out=16'h0123, then value_out=16'h0123 with a 1-cycle value_valid.
- After that: digits_out=0, count=0.
REQ-033 Empty enter and unknown code: after reset, apply 5A then 1C.
- Required: two error pulses, value_valid never asserted, all data outputs 0.
REQ-034 Hold and change: apply 69 for 10 cycles, then 72 for 10 cycles with no 00 between.
- Required: exactly 2 key_event pulses, digits_out=16'h0012.
REQ-035 Reset mid-entry: enter 7D,75, pulse reset_n low for 3 cycles asynchronously between edges.
- Required: all outputs 0 immediately on assertion.
- Required: after release, a held 70 produces one event and digits_out=16'h0000, count=1.
